// File: rtl/player_motion_ctrl_if.sv
// Player motion bundle: frame strobe, key and game inputs in; position, facing and life status out.
// The master side drives the inputs, the slave side is the motion controller.
interface player_motion_ctrl_if;
    logic       frame_clk;
    logic [3:0] keycode;
    logic       keyPress;
    logic [1:0] gameState;
    logic       hit;
    logic [9:0] PlayerX;
    logic [9:0] PlayerY;
    logic       Direction;
    logic       playerMoving;
    logic       jumping;
    logic [1:0] Lives;
    logic       dead;

    modport master (
        output frame_clk, keycode, keyPress, gameState, hit,
        input  PlayerX, PlayerY, Direction, playerMoving, jumping, Lives, dead
    );

    modport slave (
        input  frame_clk, keycode, keyPress, gameState, hit,
        output PlayerX, PlayerY, Direction, playerMoving, jumping, Lives, dead
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion: walking, jump arc, hits, respawn and game over.
// Everything advances on one Clk-domain tick derived from the frame_clk rising edge.
module player_motion_ctrl #(
    parameter int START_X        = 64,
    parameter int GROUND_Y       = 400,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 608,
    parameter int X_STEP         = 2,
    parameter int JUMP_V0        = 10,
    parameter int GRAVITY        = 1,
    parameter int RESPAWN_FRAMES = 60,
    parameter int LIVES_INIT     = 3
) (
    input logic                  Clk,
    input logic                  Reset,
    player_motion_ctrl_if.slave  bus
);
    localparam int RW = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [10:0]        X_STEP_W   = 11'(X_STEP);
    localparam logic [10:0]        X_MIN_W    = 11'(X_MIN);
    localparam logic [10:0]        X_MAX_W    = 11'(X_MAX);
    localparam logic [9:0]         START_X_W  = 10'(START_X);
    localparam logic [9:0]         GROUND_W   = 10'(GROUND_Y);
    localparam logic signed [11:0] GROUND_S   = 12'(GROUND_Y);
    localparam logic [9:0]         JUMP_Y_W   = 10'(GROUND_Y - JUMP_V0);
    localparam logic signed [11:0] GRAVITY_S  = 12'(GRAVITY);
    // The takeoff tick already applied the first JUMP_V0 step, so gravity is applied there too.
    localparam logic signed [11:0] TAKEOFF_VY = 12'(JUMP_V0 - GRAVITY);
    localparam logic [RW-1:0]      RESP_W     = RW'(RESPAWN_FRAMES);
    localparam logic [1:0]         LIVES_W    = 2'(LIVES_INIT);

    typedef enum logic [2:0] {ST_GROUND, ST_RISE, ST_FALL, ST_DEAD, ST_OVER} state_t;

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic signed [11:0] vy_q, vy_d;
    logic               dir_q, dir_d, moving_q, moving_d, hit_pend_q, hit_pend_d;
    logic [1:0]         lives_q, lives_d;
    logic [RW-1:0]      resp_q, resp_d;
    logic               fc_meta_q, fc_sync_q, fc_prev_q;

    logic               tick;
    logic [3:0]         kc;
    logic               key_l, key_r, crouch;
    logic [10:0]        x_sub, x_add;
    logic [9:0]         x_left, x_right, x_walk, y_air;
    logic signed [11:0] y_next, vy_air;

    assign tick   = fc_sync_q & ~fc_prev_q & (bus.gameState == 2'b01);
    assign kc     = bus.keyPress ? bus.keycode : 4'b0000;
    assign key_l  = kc[0] & ~kc[1];
    assign key_r  = kc[1] & ~kc[0];
    assign crouch = kc[2];

    assign x_sub   = {1'b0, x_q} - X_STEP_W;
    assign x_add   = {1'b0, x_q} + X_STEP_W;
    assign x_left  = ({1'b0, x_q} < X_MIN_W + X_STEP_W) ? X_MIN_W[9:0] : x_sub[9:0];
    assign x_right = (x_add > X_MAX_W) ? X_MAX_W[9:0] : x_add[9:0];
    assign x_walk  = key_l ? x_left : (key_r ? x_right : x_q);

    assign y_next = $signed({2'b00, y_q}) - vy_q;
    assign y_air  = y_next[11] ? 10'd0 : y_next[9:0];
    assign vy_air = y_next[11] ? 12'sd0 : (vy_q - GRAVITY_S);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_meta_q  <= 1'b0;
            fc_sync_q  <= 1'b0;
            fc_prev_q  <= 1'b0;
            state_q    <= ST_GROUND;
            x_q        <= START_X_W;
            y_q        <= GROUND_W;
            vy_q       <= 12'sd0;
            dir_q      <= 1'b0;
            moving_q   <= 1'b0;
            hit_pend_q <= 1'b0;
            lives_q    <= LIVES_W;
            resp_q     <= '0;
        end else begin
            fc_meta_q  <= bus.frame_clk;
            fc_sync_q  <= fc_meta_q;
            fc_prev_q  <= fc_sync_q;
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            hit_pend_q <= hit_pend_d;
            lives_q    <= lives_d;
            resp_q     <= resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        dir_d      = dir_q;
        moving_d   = moving_q;
        hit_pend_d = hit_pend_q;
        lives_d    = lives_q;
        resp_d     = resp_q;

        if (tick) begin
            case (state_q)
                ST_GROUND, ST_RISE, ST_FALL: begin
                    if (hit_pend_q) begin
                        hit_pend_d = 1'b0;
                        lives_d    = lives_q - 2'd1;
                        moving_d   = 1'b0;
                        if (lives_q == 2'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_DEAD;
                            resp_d  = RESP_W;
                        end
                    end else begin
                        if (key_l)      dir_d = 1'b1;
                        else if (key_r) dir_d = 1'b0;
                        if (state_q == ST_GROUND) begin
                            moving_d = (key_l | key_r) & ~crouch;
                            if (!crouch) x_d = x_walk;
                            if (kc[3] && !crouch) begin
                                vy_d    = TAKEOFF_VY;
                                y_d     = JUMP_Y_W;
                                state_d = ST_RISE;
                            end
                        end else begin
                            moving_d = 1'b0;
                            x_d      = x_walk;
                            y_d      = y_air;
                            vy_d     = vy_air;
                            if (state_q == ST_RISE) begin
                                if (vy_air <= 12'sd0) state_d = ST_FALL;
                            end else if (y_next >= GROUND_S) begin
                                y_d     = GROUND_W;
                                vy_d    = 12'sd0;
                                state_d = ST_GROUND;
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    hit_pend_d = 1'b0;
                    resp_d     = resp_q - RW'(1);
                    if (resp_q <= RW'(1)) begin
                        resp_d  = '0;
                        x_d     = START_X_W;
                        y_d     = GROUND_W;
                        vy_d    = 12'sd0;
                        dir_d   = 1'b0;
                        state_d = ST_GROUND;
                    end
                end
                default: hit_pend_d = 1'b0;
            endcase
        end

        // A hit arriving on a consuming tick is kept for the following tick.
        if (bus.hit) hit_pend_d = 1'b1;
    end

    assign bus.PlayerX      = x_q;
    assign bus.PlayerY      = y_q;
    assign bus.Direction    = dir_q;
    assign bus.playerMoving = moving_q;
    assign bus.jumping      = (state_q == ST_RISE) || (state_q == ST_FALL);
    assign bus.Lives        = lives_q;
    assign bus.dead         = (state_q == ST_DEAD) || (state_q == ST_OVER);
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: walking, clamping, jump arc, freeze, hits and game over.
module tb_player_motion_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   tick_no = 0;

    player_motion_ctrl_if bus();

    player_motion_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    // Jump arc after takeoff ticks 1..21
    int jump_y [21] = '{390, 381, 373, 366, 360, 355, 351, 348, 346, 345, 345,
                        346, 348, 351, 355, 360, 366, 373, 381, 390, 400};

    task automatic frame_tick();
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        tick_no++;
        $display("tick %0d gs=%0d kc=%b X=%0d Y=%0d dir=%0d mov=%0d jmp=%0d lives=%0d dead=%0d",
                 tick_no, bus.gameState, bus.keycode, bus.PlayerX, bus.PlayerY, bus.Direction,
                 bus.playerMoving, bus.jumping, bus.Lives, bus.dead);
    endtask

    task automatic set_keys(input logic [3:0] k);
        bus.keycode  = k;
        bus.keyPress = 1'b1;
    endtask

    task automatic pulse_hit();
        @(negedge Clk);
        bus.hit = 1'b1;
        @(negedge Clk);
        bus.hit = 1'b0;
    endtask

    task automatic test_reset();
        bus.frame_clk = 1'b0; bus.keycode = 4'b0; bus.keyPress = 1'b0;
        bus.gameState = 2'b01; bus.hit = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (bus.PlayerX !== 10'd64) begin errors++; $display("FAIL reset_x got %0d exp 64", bus.PlayerX); end
        checks++; if (bus.PlayerY !== 10'd400) begin errors++; $display("FAIL reset_y got %0d exp 400", bus.PlayerY); end
        checks++; if (bus.Direction !== 1'b0) begin errors++; $display("FAIL reset_dir got %0d exp 0", bus.Direction); end
        checks++; if (bus.playerMoving !== 1'b0) begin errors++; $display("FAIL reset_moving got %0d exp 0", bus.playerMoving); end
        checks++; if (bus.jumping !== 1'b0) begin errors++; $display("FAIL reset_jumping got %0d exp 0", bus.jumping); end
        checks++; if (bus.Lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", bus.Lives); end
        checks++; if (bus.dead !== 1'b0) begin errors++; $display("FAIL reset_dead got %0d exp 0", bus.dead); end
    endtask

    task automatic test_walk_right();
        set_keys(4'b0010);
        // First tick also checks the 3-cycle frame_clk latency
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (bus.PlayerX !== 10'd64) begin errors++; $display("FAIL latency_early got %0d exp 64", bus.PlayerX); end
        @(negedge Clk);
        checks++; if (bus.PlayerX !== 10'd66) begin errors++; $display("FAIL latency_3clk got %0d exp 66", bus.PlayerX); end
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        for (int i = 2; i <= 10; i++) begin
            frame_tick();
            checks++; if (bus.PlayerX !== 10'(64 + 2 * i)) begin errors++; $display("FAIL walk_r_x i=%0d got %0d exp %0d", i, bus.PlayerX, 64 + 2 * i); end
            checks++; if (bus.playerMoving !== 1'b1) begin errors++; $display("FAIL walk_r_moving i=%0d got %0d exp 1", i, bus.playerMoving); end
            checks++; if (bus.Direction !== 1'b0 || bus.PlayerY !== 10'd400) begin errors++; $display("FAIL walk_r_dir_y i=%0d got dir=%0d y=%0d exp 0/400", i, bus.Direction, bus.PlayerY); end
        end
    endtask

    task automatic test_walk_left_clamp();
        set_keys(4'b0001);
        repeat (40) frame_tick();
        checks++; if (bus.PlayerX !== 10'd4) begin errors++; $display("FAIL walk_l_pre got %0d exp 4", bus.PlayerX); end
        for (int i = 0; i < 5; i++) begin
            frame_tick();
            checks++; if (bus.PlayerX !== ((i == 0) ? 10'd2 : 10'd0)) begin errors++; $display("FAIL clamp_x i=%0d got %0d exp %0d", i, bus.PlayerX, (i == 0) ? 2 : 0); end
            checks++; if (bus.Direction !== 1'b1 || bus.playerMoving !== 1'b1) begin errors++; $display("FAIL clamp_dir_mov i=%0d got %0d/%0d exp 1/1", i, bus.Direction, bus.playerMoving); end
        end
        // keyPress low masks the keycode
        bus.keycode = 4'b0010; bus.keyPress = 1'b0;
        frame_tick();
        checks++; if (bus.PlayerX !== 10'd0 || bus.playerMoving !== 1'b0) begin errors++; $display("FAIL keypress_gate got x=%0d mov=%0d exp 0/0", bus.PlayerX, bus.playerMoving); end
    endtask

    task automatic test_jump();
        set_keys(4'b1000);
        frame_tick();
        checks++; if (bus.PlayerY !== 10'd390 || bus.jumping !== 1'b1) begin errors++; $display("FAIL jump_takeoff got y=%0d j=%0d exp 390/1", bus.PlayerY, bus.jumping); end
        set_keys(4'b0011);
        for (int t = 2; t <= 21; t++) begin
            frame_tick();
            checks++; if (bus.PlayerY !== 10'(jump_y[t-1])) begin errors++; $display("FAIL jump_y t=%0d got %0d exp %0d", t, bus.PlayerY, jump_y[t-1]); end
            checks++; if (bus.jumping !== ((t < 21) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL jump_flag t=%0d got %0d exp %0d", t, bus.jumping, (t < 21) ? 1 : 0); end
            checks++; if (bus.PlayerX !== 10'd0 || bus.playerMoving !== 1'b0) begin errors++; $display("FAIL jump_lr t=%0d got x=%0d mov=%0d exp 0/0", t, bus.PlayerX, bus.playerMoving); end
        end
    endtask

    task automatic test_freeze();
        set_keys(4'b1000);
        frame_tick();
        set_keys(4'b0000);
        frame_tick();
        frame_tick();
        checks++; if (bus.PlayerY !== 10'd373) begin errors++; $display("FAIL freeze_pre got %0d exp 373", bus.PlayerY); end
        bus.gameState = 2'b00;
        for (int i = 0; i < 5; i++) begin
            frame_tick();
            checks++; if (bus.PlayerY !== 10'd373 || bus.jumping !== 1'b1) begin errors++; $display("FAIL freeze_hold i=%0d got y=%0d j=%0d exp 373/1", i, bus.PlayerY, bus.jumping); end
        end
        bus.gameState = 2'b01;
        frame_tick();
        checks++; if (bus.PlayerY !== 10'd366) begin errors++; $display("FAIL freeze_resume1 got %0d exp 366", bus.PlayerY); end
        frame_tick();
        checks++; if (bus.PlayerY !== 10'd360) begin errors++; $display("FAIL freeze_resume2 got %0d exp 360", bus.PlayerY); end
        repeat (16) frame_tick();
        checks++; if (bus.PlayerY !== 10'd400 || bus.jumping !== 1'b0) begin errors++; $display("FAIL freeze_land got y=%0d j=%0d exp 400/0", bus.PlayerY, bus.jumping); end
    endtask

    task automatic test_crouch();
        set_keys(4'b0001);
        frame_tick();
        set_keys(4'b0110);
        frame_tick();
        checks++; if (bus.PlayerX !== 10'd0) begin errors++; $display("FAIL crouch_x got %0d exp 0", bus.PlayerX); end
        checks++; if (bus.Direction !== 1'b0 || bus.playerMoving !== 1'b0) begin errors++; $display("FAIL crouch_dir_mov got %0d/%0d exp 0/0", bus.Direction, bus.playerMoving); end
    endtask

    task automatic test_hit_respawn();
        set_keys(4'b0001);
        frame_tick();
        set_keys(4'b0000);
        pulse_hit();
        frame_tick();
        checks++; if (bus.Lives !== 2'd2 || bus.dead !== 1'b1) begin errors++; $display("FAIL hit_lives_dead got %0d/%0d exp 2/1", bus.Lives, bus.dead); end
        checks++; if (bus.PlayerX !== 10'd0 || bus.playerMoving !== 1'b0 || bus.jumping !== 1'b0) begin errors++; $display("FAIL hit_hold got x=%0d mov=%0d j=%0d exp 0/0/0", bus.PlayerX, bus.playerMoving, bus.jumping); end
        pulse_hit();
        repeat (59) frame_tick();
        checks++; if (bus.dead !== 1'b1 || bus.PlayerX !== 10'd0) begin errors++; $display("FAIL dead_59 got dead=%0d x=%0d exp 1/0", bus.dead, bus.PlayerX); end
        frame_tick();
        checks++; if (bus.dead !== 1'b0 || bus.PlayerX !== 10'd64 || bus.PlayerY !== 10'd400) begin errors++; $display("FAIL respawn got dead=%0d x=%0d y=%0d exp 0/64/400", bus.dead, bus.PlayerX, bus.PlayerY); end
        checks++; if (bus.Direction !== 1'b0 || bus.Lives !== 2'd2) begin errors++; $display("FAIL respawn_dir_lives got %0d/%0d exp 0/2", bus.Direction, bus.Lives); end
        frame_tick();
        checks++; if (bus.Lives !== 2'd2 || bus.dead !== 1'b0) begin errors++; $display("FAIL second_hit_ignored got %0d/%0d exp 2/0", bus.Lives, bus.dead); end
    endtask

    task automatic test_game_over();
        pulse_hit();
        frame_tick();
        checks++; if (bus.Lives !== 2'd1 || bus.dead !== 1'b1) begin errors++; $display("FAIL hit2 got %0d/%0d exp 1/1", bus.Lives, bus.dead); end
        repeat (60) frame_tick();
        checks++; if (bus.dead !== 1'b0) begin errors++; $display("FAIL respawn2 got %0d exp 0", bus.dead); end
        pulse_hit();
        frame_tick();
        set_keys(4'b0010);
        for (int i = 0; i < 3; i++) begin
            frame_tick();
            checks++; if (bus.Lives !== 2'd0 || bus.dead !== 1'b1 || bus.PlayerX !== 10'd64) begin errors++; $display("FAIL over i=%0d got lives=%0d dead=%0d x=%0d exp 0/1/64", i, bus.Lives, bus.dead, bus.PlayerX); end
        end
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        checks++; if (bus.Lives !== 2'd3 || bus.dead !== 1'b0) begin errors++; $display("FAIL over_reset got %0d/%0d exp 3/0", bus.Lives, bus.dead); end
    endtask

    task automatic test_reset_mid_jump();
        set_keys(4'b1000);
        frame_tick();
        frame_tick();
        checks++; if (bus.PlayerY !== 10'd381) begin errors++; $display("FAIL midjump_pre got %0d exp 381", bus.PlayerY); end
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        checks++; if (bus.PlayerY !== 10'd400 || bus.jumping !== 1'b0 || bus.PlayerX !== 10'd64) begin errors++; $display("FAIL midjump_reset got y=%0d j=%0d x=%0d exp 400/0/64", bus.PlayerY, bus.jumping, bus.PlayerX); end
    endtask

    initial begin
        test_reset();
        test_walk_right();
        test_walk_left_clamp();
        test_jump();
        test_freeze();
        test_crouch();
        test_hit_respawn();
        test_game_over();
        test_reset_mid_jump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
